// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART type package (uart_types).
// Holds the arbiter FSM state encoding and the requester-count ceiling used
// by uart_tx_arbiter and uart_rr_arbiter. No ports.

package uart_types;

  localparam int UART_ARB_MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    START = 3'd2,
    ACK   = 3'd3,
    DONE  = 3'd4
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte-stream requesters / UART transmitter and the
// packet arbiter.
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   tx_start/tx_data/tx_busy              : transmitter handshake
//   grant_id/arb_busy/pkt_abort           : arbiter status
// Modports: slave = arbiter side, master = requesters + transmitter side.

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [GW-1:0]        grant_id;
  logic                 arb_busy;
  logic                 pkt_abort;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, arb_busy, pkt_abort
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, arb_busy, pkt_abort
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick.
//   valid       : request vector
//   rr_ptr      : highest-priority index for this round
//   grant_oh    : one-hot winner (all zero when nothing is valid)
//   grant_idx   : binary winner index (0 when nothing is valid)
//   grant_valid : some requester won

module uart_rr_arbiter
  import uart_types::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant_oh,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);
  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > UART_ARB_MAX_REQ) begin : g_bad_num_req
    $error("uart_rr_arbiter: NUM_REQ out of range 2..%0d", UART_ARB_MAX_REQ);
  end

  int idx;

  // Walk upward from rr_ptr with wrap; the first valid index wins.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && valid[idx]) begin
        grant_valid   = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters. A grant stays locked until the granted
// requester's last byte has left the transmitter, so packets never interleave.
//
// Ports: clk, rst (synchronous, active-high), bus (uart_tx_arbiter_if.slave).
// Parameters: NUM_REQ (2..8), TIMEOUT_CYCLES (mid-packet idle limit).
// Build option: define UART_TX_ARB_TIMEOUT_EN to abort a locked packet whose
// requester stays silent for TIMEOUT_CYCLES HOLD cycles; otherwise HOLD waits
// forever and pkt_abort is constant 0.
//
// state | meaning
// IDLE  | arbitrate among valid requesters (transmitter idle)
// HOLD  | locked mid-packet, waiting for grantee's next byte
// START | drive tx_start for one cycle
// ACK   | wait for tx_busy to rise
// DONE  | wait for tx_busy to fall

module uart_tx_arbiter
  import uart_types::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int            GW       = $clog2(NUM_REQ);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  uart_arb_state_t    state, next_state;
  logic [GW-1:0]      rr_ptr, grant_id_q, arb_idx, xfer_idx, next_ptr;
  logic [NUM_REQ-1:0] arb_oh, ready;
  logic               arb_any, xfer, abort, release_grant;
  logic               last_q, busy_q, timed_out;
  logic [7:0]         tx_data_q;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid       (bus.req_valid),
    .rr_ptr      (rr_ptr),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_any)
  );

  assign next_ptr      = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
  assign xfer_idx      = (state == IDLE) ? arb_idx : grant_id_q;
  assign release_grant = ((state == DONE) && !bus.tx_busy && last_q) || abort;

  // IDLE gates arbitration on last cycle's tx_busy, which keeps tx_busy out
  // of the combinational req_ready cone while still holding off a
  // transmitter that is busy after reset.
  always_ff @(posedge clk) begin
    busy_q <= bus.tx_busy;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] idle_cnt;

  // Held at zero outside HOLD, so it is already clear on HOLD entry.
  always_ff @(posedge clk) begin
    if (rst || state != HOLD) begin
      idle_cnt <= '0;
    end else if (!xfer && !timed_out) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timed_out = (idle_cnt == TO_LIMIT);
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    next_state = state;
    ready      = '0;
    xfer       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && !busy_q && arb_any) begin
          ready      = arb_oh;
          xfer       = 1'b1;
          next_state = START;
        end
      end
      HOLD: begin
        ready[grant_id_q] = bus.req_valid[grant_id_q];
        if (bus.req_valid[grant_id_q]) begin
          xfer       = 1'b1;
          next_state = START;
        end else if (timed_out) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      START: next_state = ACK;
      ACK:   if (bus.tx_busy) next_state = DONE;
      DONE:  if (!bus.tx_busy) next_state = last_q ? IDLE : HOLD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (xfer) begin
        tx_data_q  <= bus.req_data[8*int'(xfer_idx) +: 8];
        last_q     <= bus.req_last[xfer_idx];
        grant_id_q <= xfer_idx;
      end
      if (release_grant) rr_ptr <= next_ptr;
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_start  = (state == START);
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.arb_busy  = (state != IDLE);
  assign bus.pkt_abort = abort;

endmodule
